// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : multi_edge_detector
// Description : Per-channel synchroniser, optional debounce filter and run-time
//               selectable edge classifier with one-cycle pulse and sticky,
//               write-1-to-clear event flags.
//               Debounce is compiled in with MULTI_EDGE_DETECTOR_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_edge_detector #(
    parameter int OPTN_NUM_CHANNELS  = 1,
    parameter int OPTN_SYNC_DEPTH    = 2,
    parameter int OPTN_FILTER_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [OPTN_NUM_CHANNELS-1:0]   i_async,
    input  logic [2*OPTN_NUM_CHANNELS-1:0] i_edge_mode,
    input  logic [OPTN_NUM_CHANNELS-1:0]   i_clear,
    output logic [OPTN_NUM_CHANNELS-1:0]   o_level,
    output logic [OPTN_NUM_CHANNELS-1:0]   o_pulse,
    output logic [OPTN_NUM_CHANNELS-1:0]   o_event,
    output logic                           o_event_any
);

    // Elaboration-time parameter sanity checks
    if (OPTN_NUM_CHANNELS < 1) begin : g_check_channels
        $error("OPTN_NUM_CHANNELS must be >= 1");
    end
    if (OPTN_SYNC_DEPTH < 2) begin : g_check_sync_depth
        $error("OPTN_SYNC_DEPTH must be >= 2");
    end
    if (OPTN_FILTER_CYCLES < 1) begin : g_check_filter
        $error("OPTN_FILTER_CYCLES must be >= 1");
    end

    logic [OPTN_NUM_CHANNELS-1:0] match;

    for (genvar i = 0; i < OPTN_NUM_CHANNELS; i++) begin : g_channel
        logic [OPTN_SYNC_DEPTH-1:0] sync_ff;
        logic                       sync;
        logic                       level;
        logic                       level_d1;
        logic                       rise;
        logic                       fall;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_ff <= '0;
            end else begin
                sync_ff <= {sync_ff[OPTN_SYNC_DEPTH-2:0], i_async[i]};
            end
        end

        assign sync = sync_ff[OPTN_SYNC_DEPTH-1];

`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
        localparam int CNT_W = $clog2(OPTN_FILTER_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPTN_FILTER_CYCLES - 1);

        logic [CNT_W-1:0] cnt;

        // Any return of sync to the current level discards the partial window
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync == level) begin
                cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync;
            end else begin
                cnt   <= cnt + 1'b1;
            end
        end
`else
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level <= 1'b0;
            end else begin
                level <= sync;
            end
        end
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_d1 <= 1'b0;
            end else begin
                level_d1 <= level;
            end
        end

        assign rise       = level & ~level_d1;
        assign fall       = ~level & level_d1;
        assign match[i]   = (i_edge_mode[2*i] & rise) | (i_edge_mode[2*i+1] & fall);
        assign o_level[i] = level;
    end

    // A new match in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pulse <= '0;
            o_event <= '0;
        end else begin
            o_pulse <= match;
            o_event <= (o_event & ~i_clear) | match;
        end
    end

    assign o_event_any = |o_event;

endmodule
`default_nettype wire
